// File: rtl/reg_scoreboard_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regdec_pkg
//  Brief    : Shared sizes, typedefs and popcount helper for the register
//             scoreboard decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package regdec_pkg;

    localparam int ADDR_W     = 5;
    localparam int NREG       = 1 << ADDR_W;

    // Upper bound for the popcount helper so any legal ADDR_W instance can use it.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_NREG   = 1 << MAX_ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [NREG-1:0]   reg_vec_t;

    function automatic logic [MAX_ADDR_W:0] popcount(input logic [MAX_NREG-1:0] v);
        logic [MAX_ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_NREG; i++) begin
            cnt = cnt + {{MAX_ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_dec_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_dec
//  Brief    : Enabled binary-to-one-hot decoder, 2^ADDR_W outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int ADDR_W = 5,
    localparam int NREG  = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [NREG-1:0]   out
);

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_bit
            assign out[i] = en && (addr == ADDR_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard_dec.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_dec
//  Brief    : Destination decoder with pending-write scoreboard feeding the
//             register-file write port. Optional macro SCOREBOARD_STATS_EN
//             adds a saturating issue-stall counter output.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard_dec #(
    parameter int ADDR_W   = regdec_pkg::ADDR_W,
    parameter int ZERO_REG = 31,
    parameter int ZERO_EN  = 1,
    localparam int NREG    = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREG-1:0]   wr_en_onehot,
`ifdef SCOREBOARD_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [NREG-1:0]   busy_vec,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err_wb_idle
);

    import regdec_pkg::*;

    logic [NREG-1:0]     r_busy;
    logic [NREG-1:0]     r_wr_en;
    logic [ADDR_W:0]     r_cnt;
    logic                r_err;

    logic                w_zero_iss;
    logic                w_zero_wb;
    logic                w_wb_same;
    logic                w_fire;
    logic [NREG-1:0]     w_set;
    logic [NREG-1:0]     w_clr;
    logic [NREG-1:0]     w_wr;
    logic [NREG-1:0]     w_busy_nxt;
    logic [MAX_ADDR_W:0] w_pc;

    assign w_zero_iss = (ZERO_EN != 0) && (iss_addr == ADDR_W'(ZERO_REG));
    assign w_zero_wb  = (ZERO_EN != 0) && (wb_addr  == ADDR_W'(ZERO_REG));
    assign w_wb_same  = wb_valid && (wb_addr == iss_addr);

    // A WAW hazard stalls unless the same register retires this cycle.
    assign iss_ready  = w_zero_iss || !r_busy[iss_addr] || w_wb_same;
    assign w_fire     = iss_valid && iss_ready;

    onehot_dec #(.ADDR_W(ADDR_W)) u_set_dec (
        .addr (iss_addr),
        .en   (w_fire && !w_zero_iss),
        .out  (w_set)
    );

    onehot_dec #(.ADDR_W(ADDR_W)) u_clr_dec (
        .addr (wb_addr),
        .en   (wb_valid),
        .out  (w_clr)
    );

    onehot_dec #(.ADDR_W(ADDR_W)) u_wr_dec (
        .addr (wb_addr),
        .en   (wb_valid && !w_zero_wb),
        .out  (w_wr)
    );

    // Set is applied after clear so a same-cycle reissue keeps the bit busy.
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;
    assign w_pc       = popcount(MAX_NREG'(w_busy_nxt));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= '0;
            r_wr_en <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wr_en <= w_wr;
            r_cnt   <= w_pc[ADDR_W:0];
            if (wb_valid && !r_busy[wb_addr] && !w_zero_wb) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (iss_valid && !iss_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

    assign busy_a       = r_busy[rd_addr_a];
    assign busy_b       = r_busy[rd_addr_b];
    assign busy_vec     = r_busy;
    assign wr_en_onehot = r_wr_en;
    assign busy_cnt     = r_cnt;
    assign err_wb_idle  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard_dec
//  Brief    : Self-checking bench for reg_scoreboard_dec against an
//             array-based scoreboard model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard_dec;

    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int ZR     = 31;
    localparam int ZE     = 1;

    logic              clk;
    logic              reset_n;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              busy_a;
    logic              busy_b;
    logic [NREG-1:0]   wr_en_onehot;
    logic [NREG-1:0]   busy_vec;
    logic [ADDR_W:0]   busy_cnt;
    logic              err_wb_idle;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    reg_scoreboard_dec #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZR),
        .ZERO_EN  (ZE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iss_valid    (iss_valid),
        .iss_addr     (iss_addr),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .wr_en_onehot (wr_en_onehot),
`ifdef SCOREBOARD_STATS_EN
        .stall_cnt    (stall_cnt),
`endif
        .busy_vec     (busy_vec),
        .busy_cnt     (busy_cnt),
        .err_wb_idle  (err_wb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one flag per architectural register.
    bit              m_busy [NREG];
    logic [NREG-1:0] m_wr;
    bit              m_err;
    int              m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_zero(input int a);
        return (ZE != 0) && (a == ZR);
    endfunction

    function automatic logic [NREG-1:0] m_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_wr    = '0;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, ":busy_vec"}, 64'(busy_vec), 64'(m_vec()));
        chk({pfx, ":busy_cnt"}, 64'(busy_cnt), 64'(m_cnt()));
        chk({pfx, ":wr_en"}, 64'(wr_en_onehot), 64'(m_wr));
        chk({pfx, ":err"}, 64'(err_wb_idle), 64'(m_err));
`ifdef SCOREBOARD_STATS_EN
        chk({pfx, ":stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`endif
    endtask

    // One cycle: drive at negedge, check against the model, then advance it.
    task automatic step(input bit iv, input int ia, input bit wv, input int wa,
                        input int ra, input int rb);
        bit rdy;
        @(negedge clk);
        iss_valid = iv;
        iss_addr  = ia[ADDR_W-1:0];
        wb_valid  = wv;
        wb_addr   = wa[ADDR_W-1:0];
        rd_addr_a = ra[ADDR_W-1:0];
        rd_addr_b = rb[ADDR_W-1:0];
        #1;
        rdy = is_zero(ia) || !m_busy[ia] || (wv && wa == ia);
        chk("iss_ready", 64'(iss_ready), 64'(rdy));
        chk("busy_a", 64'(busy_a), 64'(m_busy[ra]));
        chk("busy_b", 64'(busy_b), 64'(m_busy[rb]));
        check_state("step");
        if (iv && !rdy && m_stall < 65535) m_stall++;
        if (wv && !m_busy[wa] && !is_zero(wa)) m_err = 1'b1;
        m_wr = '0;
        if (wv && !is_zero(wa)) m_wr[wa] = 1'b1;
        if (wv) m_busy[wa] = 1'b0;
        if (iv && rdy && !is_zero(ia)) m_busy[ia] = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst:busy_vec", 64'(busy_vec), 64'd0);
        chk("rst:busy_cnt", 64'(busy_cnt), 64'd0);
        chk("rst:wr_en", 64'(wr_en_onehot), 64'd0);
        chk("rst:err", 64'(err_wb_idle), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        model_reset();
        #3;
        check_state("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-stream after three issues.
        step(1, 1, 0, 0, 1, 2);
        step(1, 2, 0, 0, 1, 2);
        step(1, 3, 0, 0, 1, 2);
        idle();
        apply_reset();

        // Issue 7, WAW stall, writeback 7.
        step(1, 7, 0, 0, 7, 0);
        chk("i7:ready_again", 64'(iss_ready), 64'd1);
        step(1, 7, 0, 0, 7, 7);
        chk("i7:busy_cnt", 64'(busy_cnt), 64'd1);
        chk("i7:stalled", 64'(iss_ready), 64'd0);
        step(0, 0, 1, 7, 7, 0);
        idle();
        chk("wb7:wr_en", 64'(wr_en_onehot), 64'h80);
        chk("wb7:busy7", 64'(busy_vec[7]), 64'd0);

        // Same-cycle writeback and reissue of register 4.
        step(1, 4, 0, 0, 4, 0);
        step(1, 4, 1, 4, 4, 0);
        idle();
        chk("same4:busy4", 64'(busy_vec[4]), 64'd1);
        chk("same4:wr_en", 64'(wr_en_onehot), 64'h10);
        step(0, 0, 1, 4, 0, 0);

        // Zero register: never busy, never written, no error.
        step(1, 31, 0, 0, 31, 31);
        step(0, 0, 1, 31, 31, 31);
        idle();
        chk("zr:wr_en", 64'(wr_en_onehot), 64'd0);
        chk("zr:err", 64'(err_wb_idle), 64'd0);

        // Writeback to an idle register sets the sticky error.
        step(0, 0, 1, 9, 9, 0);
        idle();
        chk("err9:set", 64'(err_wb_idle), 64'd1);
        for (int i = 0; i < 6; i++) step(1, i + 10, 1, i + 10, i, i + 10);
        idle();
        apply_reset();

        // Fill every non-zero register, then stall ten cycles.
        for (int i = 0; i < NREG - 1; i++) step(1, i, 0, 0, i, 31);
        idle();
        chk("full:busy_cnt", 64'(busy_cnt), 64'(NREG - 1));
        for (int i = 0; i < 10; i++) step(1, (i * 3) % (NREG - 1), 0, 0, i, 31);
        idle();
`ifdef SCOREBOARD_STATS_EN
        chk("full:stall_cnt", 64'(stall_cnt), 64'd10);
`endif
        for (int i = 0; i < NREG - 1; i++) step(0, 0, 1, i, i, 0);
        idle();
        apply_reset();

        // Randomized traffic concentrated on a few registers plus the zero register.
        for (int n = 0; n < 400; n++) begin
            int ia, wa;
            ia = ($urandom_range(0, 7) == 0) ? ZR : int'($urandom_range(0, 9));
            wa = ($urandom_range(0, 7) == 0) ? ZR : int'($urandom_range(0, 9));
            step(bit'($urandom_range(0, 1)), ia, bit'($urandom_range(0, 2) == 0), wa,
                 int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 10)));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
